// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter: default width and controller state encoding.
package addsub_pkg;

  localparam int unsigned ADDSUB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub.sv
// Combinational adder/subtractor: subtract is a + ~b + 1, ovf from the effective operands.
module add_sub
  import addsub_pkg::*;
#(
  parameter int unsigned W = ADDSUB_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] sum_c,
  output logic         carry_out,
  output logic         ovf_c
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff              = b ^ {W{mode}};
    {carry_out, sum_c} = {1'b0, a} + {1'b0, b_eff} + (W+1)'(mode);
    ovf_c              = (a[W-1] == b_eff[W-1]) && (sum_c[W-1] != a[W-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end around a single add_sub datapath,
// one operation in flight: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int unsigned W = ADDSUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req0_mode,
  input  logic         req1_mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_carry,
  output logic         rsp_ovf,
  output logic [7:0]   op_count
);

  state_t       state;
  state_t       state_nxt;
  logic         grant_id_c;
  logic         accept_c;
  logic         last_grant;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_mode;
  logic         op_id;
  logic [W-1:0] sum_c;
  logic         carry_c;
  logic         ovf_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)  state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Grant goes to the requester not served last when both contend.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id_c = 1'b0;
    if (state == IDLE && rst_n) begin
      if (req0_valid && req1_valid) grant_id_c = ~last_grant;
      else                          grant_id_c = req1_valid;
      req0_ready = req0_valid && !grant_id_c;
      req1_ready = req1_valid &&  grant_id_c;
    end
  end

  assign accept_c = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_mode    <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept_c) begin
      op_a       <= grant_id_c ? req1_a    : req0_a;
      op_b       <= grant_id_c ? req1_b    : req0_b;
      op_mode    <= grant_id_c ? req1_mode : req0_mode;
      op_id      <= grant_id_c;
      last_grant <= grant_id_c;
    end
  end

  add_sub #(.W(W)) u_add_sub (
    .a         (op_a),
    .b         (op_b),
    .mode      (op_mode),
    .sum_c     (sum_c),
    .carry_out (carry_c),
    .ovf_c     (ovf_c)
  );

  // Result registers load in EXEC and hold until the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      op_count  <= 8'd0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_sum   <= sum_c;
      rsp_carry <= carry_c;
      rsp_ovf   <= ovf_c;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      op_count  <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a cycle-level reference model checked every cycle.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  localparam int unsigned W = ADDSUB_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_mode = 1'b0, req1_mode = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry, rsp_ovf;
  logic [7:0]   op_count;

  int checks = 0;
  int errors = 0;

  addsub_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_age -1 = free, 0 = operation just taken, >=1 = result owed.
  int       m_age = -1;
  bit       m_last = 1'b1;
  int       m_count = 0;
  int       m_a, m_b;
  bit       m_mode, m_id;
  int       e_sum;
  bit       e_carry, e_ovf, e_id;
  bit       x0, x1;
  int       sa, sb, res;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_age = -1; m_last = 1'b1; m_count = 0;
      chk("m_rst_rsp_valid", rsp_valid, 0);
      chk("m_rst_req0_ready", req0_ready, 0);
      chk("m_rst_req1_ready", req1_ready, 0);
      chk("m_rst_op_count", op_count, 0);
    end else begin
      x0 = 1'b0; x1 = 1'b0;
      if (m_age < 0) begin
        if (req0_valid && req1_valid) begin
          if (m_last) x0 = 1'b1; else x1 = 1'b1;
        end else if (req0_valid) x0 = 1'b1;
        else if (req1_valid)     x1 = 1'b1;
      end
      chk("m_req0_ready", req0_ready, x0);
      chk("m_req1_ready", req1_ready, x1);
      chk("m_rsp_valid", rsp_valid, (m_age >= 1) ? 1 : 0);
      chk("m_op_count", op_count, m_count);
      if (m_age >= 1) begin
        chk("m_rsp_sum", rsp_sum, e_sum);
        chk("m_rsp_carry", rsp_carry, e_carry);
        chk("m_rsp_ovf", rsp_ovf, e_ovf);
        chk("m_rsp_id", rsp_id, e_id);
      end
      if (m_age < 0) begin
        if (x0 || x1) begin
          m_id   = x1;
          m_a    = x1 ? int'(req1_a) : int'(req0_a);
          m_b    = x1 ? int'(req1_b) : int'(req0_b);
          m_mode = x1 ? req1_mode : req0_mode;
          m_last = x1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        sa = (m_a >= 32768) ? m_a - 65536 : m_a;
        sb = (m_b >= 32768) ? m_b - 65536 : m_b;
        res     = m_mode ? sa - sb : sa + sb;
        e_ovf   = (res > 32767) || (res < -32768);
        e_carry = m_mode ? (m_a >= m_b) : (m_a + m_b > 65535);
        e_sum   = (m_mode ? m_a - m_b + 65536 : m_a + m_b) % 65536;
        e_id    = m_id;
        m_age   = 1;
      end else if (rsp_ready) begin
        m_age   = -1;
        m_count = (m_count + 1) % 256;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One operation from an idle block with rsp_ready high; literal expectations supplied by caller.
  task automatic single_op(input bit id, input logic [15:0] a, input logic [15:0] b, input bit mode,
                           input logic [15:0] xs, input bit xc, input bit xo, input string tag);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = mode; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = mode; end
    @(negedge clk);
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b; req0_mode = ~mode; req1_mode = ~mode;
    @(negedge clk);
    chk({tag, "_exec_valid"}, rsp_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_sum"}, rsp_sum, xs);
    chk({tag, "_carry"}, rsp_carry, xc);
    chk({tag, "_ovf"}, rsp_ovf, xo);
    chk({tag, "_id"}, rsp_id, id);
    tick();
  endtask

  int grants[$];
  int hs_cycles[$];
  int hs;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    single_op(1'b0, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, "add");
    single_op(1'b1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
    single_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
    single_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

    // Backpressure: result must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_mode = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_exec_ready", {req0_ready, req1_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_sum", rsp_sum, 16'h0100);
      chk("bp_hold_ready", {req0_ready, req1_ready}, 0);
    end
    tick();
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_last_valid", rsp_valid, 1);
    chk("bp_count_before", op_count, 4);
    @(negedge clk);
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_count_after", op_count, 5);
    tick();

    // Reset during EXEC discards the operation.
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_mode = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_exec_valid", rsp_valid, 0);
    chk("rst_exec_count", op_count, 0);
    chk("rst_exec_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("rst_no_rsp", rsp_valid, 0);
    tick();

    // 256 operations with shifting operands wrap the counter back to zero.
    hs = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 256 * 3 + 30; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) hs++;
      if (hs == 256) break;
      tick();
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_mode = 1'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_mode = 1'($urandom);
    end
    chk("wrap_handshakes", hs, 256);
    chk("wrap_count_255", op_count, 255);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count_0", op_count, 0);
    tick();

    // Round-robin from reset: req0 wins the first tie, then alternation.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'h0010; req0_b = 16'h0001; req1_a = 16'h0020; req1_b = 16'h0002;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid && rsp_ready) hs_cycles.push_back(c);
      if (c != 11) tick();
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rr_grants", grants.size(), 4);
    chk("rr_responses", hs_cycles.size(), 4);
    if (grants.size() == 4) begin
      chk("rr_grant0", grants[0], 0);
      chk("rr_grant1", grants[1], 1);
      chk("rr_grant2", grants[2], 0);
      chk("rr_grant3", grants[3], 1);
    end
    for (int i = 1; i < hs_cycles.size(); i++)
      chk("rr_spacing", hs_cycles[i] - hs_cycles[i-1], 3);
    chk("rr_count", op_count, 4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each, requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each, operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, W bits each, operands.
REQ-007 The block SHALL have ports req0_mode and req1_mode, input, 1 bit each: 0 = a+b, 1 = a-b.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, result available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit, consumer takes the result.
REQ-010 The block SHALL have port rsp_id, output, 1 bit, index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_sum, output, W bits, result.
REQ-012 The block SHALL have port rsp_carry, output, 1 bit, adder carry-out (for subtract, 1 = no borrow).
REQ-013 The block SHALL have port rsp_ovf, output, 1 bit, two's-complement signed overflow.
REQ-014 The block SHALL have port op_count, output, 8 bits, completed-response counter.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE with at least one reqN_valid high, the block SHALL assert reqN_ready combinationally for the granted requester only, capture its a, b, mode and id on that clock edge, and move to EXEC.
REQ-017 reqN_ready SHALL be low in EXEC and RESP, and SHALL never be high for both requesters in the same cycle.
REQ-018 Arbitration SHALL be round-robin:
- when only one requester is valid, it is granted;
- when both are valid, the requester not granted last is granted;
- the last-grant pointer updates only on acceptance.
REQ-019 EXEC SHALL last exactly one cycle, drive the captured operands through the adder/subtractor (b XOR {W{mode}}, carry-in = mode), register sum, carry, ovf and id into the rsp registers, and move to RESP.
REQ-020 rsp_ovf SHALL be computed from the effective operands (a, b XOR {W{mode}}) as: MSBs of a and effective b equal, and MSB of sum differs from MSB of a.
REQ-021 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held stable until rsp_ready is high at a clock edge; the FSM then returns to IDLE.
REQ-022 Latency SHALL be: accept at edge N, rsp_valid high from the cycle after edge N+1; peak throughput is one operation per 3 cycles with rsp_ready held high.
REQ-023 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-024 A new request SHALL NOT be accepted in the cycle the response is consumed; acceptance resumes in the following IDLE cycle.
REQ-025 op_count SHALL increment by 1 on each response handshake (rsp_valid and rsp_ready) and wrap from 255 to 0.
REQ-026 Changes on reqN_a, reqN_b or reqN_mode after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-027 While rst_n is low, the block SHALL immediately and asynchronously force:
- state = IDLE;
- rsp_valid, rsp_id, rsp_sum, rsp_carry and rsp_ovf = 0;
- op_count = 0;
- last-grant pointer = 1, so req0 wins the first tie.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response and no count increment.
REQ-029 reqN_ready SHALL be 0 while rst_n is low.

Structure
REQ-030 The state encoding (IDLE/EXEC/RESP) SHALL be defined in the shared package addsub_pkg.
REQ-031 The default width constant ADDSUB_W = 16 SHALL be defined in addsub_pkg.
REQ-032 The datapath SHALL be a single instance of the team's add_sub 16-bit adder/subtractor sub-module (mode, carry_out), with the block adding only the registers, FSM and arbiter around it.

Verification
REQ-033 The bench SHALL cover each of the following directed scenarios:
- Single add: req0 valid, a=0x1234, b=0x0FF0, mode=0 -> req0_ready same cycle; 2 cycles later rsp_sum=0x2224, carry=0, ovf=0, id=0.
- Subtract with borrow: req1 valid, a=0x0001, b=0x0002, mode=1 -> rsp_sum=0xFFFF, carry=0, ovf=0, id=1.
- Signed overflow: a=0x7FFF, b=0x0001, mode=0 -> rsp_sum=0x8000, ovf=1; then a=0x8000, b=0x0001, mode=1 -> rsp_sum=0x7FFF, ovf=1, carry=1.
- Round-robin: both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1; responses spaced 3 cycles; op_count=4.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no readyN asserted; response completes on the first rsp_ready=1 edge.
- Reset mid-operation: rst_n low during EXEC -> rsp_valid=0 and op_count=0 immediately; after release, a 256-operation run wraps op_count to 0.
